disp_wr_arbiter: RTL and testbench
==================================

// Module: disp_wr_arbiter
// PURPOSE
//  Shares the display text-RAM write port (7b addr, 4b digit, active-low wen/men)
//  between three character sources: link-error reporter (ERR), telemetry receiver
//  (RX) and telemetry transmitter (TX). Replaces the static mode mux feeding display.
//  Each source gets a 1-entry capture buffer; a sequencer issues 1-cycle write strobes.
//  ERR has strict priority; RX and TX alternate round-robin.
// PARAMETERS
//  ADDR_W    7    display address width
//  DATA_W    4    display digit width
//  MAX_ADDR  122  highest legal address; larger requests are dropped
//  CNT_W     8    width of drop counter (saturating)
// PORTS
//  clk          in   1       display clock
//  rst_n        in   1       async active-low reset
//  i_src_en     in   3       source enable {ERR,RX,TX}; 0 = ignore and flush
//  i_err_flag   in   1       ERR write request level
//  i_err_addr   in   ADDR_W  ERR address
//  i_err_data   in   DATA_W  ERR digit
//  i_rx_flag    in   1       RX write request level
//  i_rx_addr    in   ADDR_W  RX address
//  i_rx_data    in   DATA_W  RX digit
//  i_tx_flag    in   1       TX write request level
//  i_tx_addr    in   ADDR_W  TX address
//  i_tx_data    in   DATA_W  TX digit
//  o_disp_wen   out  1       display write enable, active low
//  o_disp_men   out  1       display memory enable, active low (== o_disp_wen)
//  o_disp_adr   out  ADDR_W  display address
//  o_disp_d     out  DATA_W  display digit
//  o_grant      out  3       one-hot source of current write {ERR,RX,TX}
//  o_busy       out  1       sequencer not in IDLE
//  o_drop_cnt   out  CNT_W   dropped requests, saturating
// BEHAVIOUR
//  Reset (async, any state): wen=men=1, adr=0, d=0, grant=0, busy=0, drop_cnt=0,
//   all pending=0, flag delay regs=0, rr pointer=RX, FSM=IDLE.
//  Capture: per source, rise = flag & ~flag_q (flag_q registered each clk).
//   rise & en & addr<=MAX_ADDR: pend<=1, latch addr/data on that edge.
//   rise & en & addr>MAX_ADDR: no capture, drop_cnt+1.
//   rise while pend=1 and not being granted this cycle: overwrite, drop_cnt+1.
//   grant and new rise same cycle on same source: pend stays 1 with new data, no drop.
//   en=0: pend cleared, rises ignored (not counted).
//   Multiple drop events same cycle add their count; saturates at 2^CNT_W-1.
//  FSM: IDLE -> SETUP -> WRITE -> HOLD -> IDLE.
//   IDLE: if any pend, select winner, copy its buffer to adr/d, clear its pend,
//    set grant, go SETUP. Else stay; grant=0.
//   SETUP: adr/d stable, wen=men=1.  WRITE: wen=men=0 exactly one cycle.
//   HOLD: wen=men=1, adr/d held; grant clears on exit.
//  Selection: ERR if pending; else if RX and TX both pending, take rr pointer
//   and toggle pointer; else the single pending one (pointer toggles to other).
//  Latency: rise seen at edge N -> pend at N; SETUP at N+1; wen low N+2..N+3.
//   One write per 4 cycles max; adr/d change only on IDLE->SETUP.
//  busy=1 in SETUP/WRITE/HOLD. Disabling a granted source does not abort it.
// TESTING
//  Reset: rst_n low mid-WRITE -> wen=men=1, grant=0, drop_cnt=0 asynchronously.
//  Single RX rise addr=5 d=7 -> one wen-low cycle at adr=5 d=7, 2 cycles after edge.
//  RX, TX, ERR rise same cycle -> writes ERR, RX, TX order; drop_cnt=0.
//  RX rises twice (d=1, d=2) while pend -> one RX write d=2; drop_cnt=1.
//  TX addr=123 -> no write, drop_cnt=1; 300 bad requests -> drop_cnt=255.
//  i_src_en=3'b011 with ERR pending -> ERR flushed, never written, no drop count.

Source files
------------

// File: rtl/disp_wr_if.sv
// Display text-RAM write port: active-low write/memory enables plus address and digit.
interface disp_wr_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 4
);
  logic              wen;
  logic              men;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] d;

  modport master (output wen, men, adr, d);
  modport slave  (input  wen, men, adr, d);
endinterface

// File: rtl/disp_wr_arbiter.sv
// Shares the display write port among ERR, RX and TX character sources.
// ERR has strict priority; RX and TX alternate; every write is a 4-cycle strobe sequence.
module disp_wr_arbiter #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned MAX_ADDR = 122,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        i_src_en,
  input  logic              i_err_flag,
  input  logic [ADDR_W-1:0] i_err_addr,
  input  logic [DATA_W-1:0] i_err_data,
  input  logic              i_rx_flag,
  input  logic [ADDR_W-1:0] i_rx_addr,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_tx_flag,
  input  logic [ADDR_W-1:0] i_tx_addr,
  input  logic [DATA_W-1:0] i_tx_data,
  disp_wr_if.master         disp,
  output logic [2:0]        o_grant,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_drop_cnt
);

  localparam int unsigned SRC_TX  = 0;
  localparam int unsigned SRC_RX  = 1;
  localparam int unsigned SRC_ERR = 2;
  localparam logic [ADDR_W:0] MAX_A = (ADDR_W+1)'(MAX_ADDR);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WRITE = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        flag_s, rise_s, elig_s, sel_s, take_s;
  logic [2:0]        flag_q;
  logic [2:0]        pend_q, pend_d;
  logic [ADDR_W-1:0] addr_in_s [3];
  logic [DATA_W-1:0] data_in_s [3];
  logic [ADDR_W-1:0] abuf_q [3];
  logic [ADDR_W-1:0] abuf_d [3];
  logic [DATA_W-1:0] dbuf_q [3];
  logic [DATA_W-1:0] dbuf_d [3];
  logic              rr_q, rr_d, rr_sel_s;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic [2:0]        grant_q, grant_d;
  logic              wen_q, wen_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [1:0]        drop_inc_s;
  logic [CNT_W+1:0]  drop_sum_s;

  assign flag_s = {i_err_flag, i_rx_flag, i_tx_flag};
  assign addr_in_s[SRC_TX]  = i_tx_addr;
  assign addr_in_s[SRC_RX]  = i_rx_addr;
  assign addr_in_s[SRC_ERR] = i_err_addr;
  assign data_in_s[SRC_TX]  = i_tx_data;
  assign data_in_s[SRC_RX]  = i_rx_data;
  assign data_in_s[SRC_ERR] = i_err_data;

  // Winner selection among enabled pending sources; rr_q=0 favours RX, 1 favours TX.
  always_comb begin
    elig_s   = pend_q & i_src_en;
    sel_s    = 3'b000;
    rr_sel_s = rr_q;
    if (elig_s[SRC_ERR]) begin
      sel_s = 3'b100;
    end else if (elig_s[SRC_RX] && elig_s[SRC_TX]) begin
      sel_s    = rr_q ? 3'b001 : 3'b010;
      rr_sel_s = ~rr_q;
    end else if (elig_s[SRC_RX]) begin
      sel_s    = 3'b010;
      rr_sel_s = 1'b1;
    end else if (elig_s[SRC_TX]) begin
      sel_s    = 3'b001;
      rr_sel_s = 1'b0;
    end else begin
      sel_s    = 3'b000;
      rr_sel_s = rr_q;
    end
  end

  // Write sequencer next state and registered display-port values.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    d_d     = d_q;
    grant_d = grant_q;
    wen_d   = 1'b1;
    rr_d    = rr_q;
    take_s  = 3'b000;
    case (state_q)
      ST_IDLE: begin
        if (|sel_s) begin
          take_s  = sel_s;
          grant_d = sel_s;
          rr_d    = rr_sel_s;
          state_d = ST_SETUP;
          case (sel_s)
            3'b100:  begin adr_d = abuf_q[SRC_ERR]; d_d = dbuf_q[SRC_ERR]; end
            3'b010:  begin adr_d = abuf_q[SRC_RX];  d_d = dbuf_q[SRC_RX];  end
            3'b001:  begin adr_d = abuf_q[SRC_TX];  d_d = dbuf_q[SRC_TX];  end
            default: begin adr_d = adr_q;           d_d = d_q;             end
          endcase
        end else begin
          grant_d = 3'b000;
        end
      end
      ST_SETUP: begin
        wen_d   = 1'b0;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        grant_d = 3'b000;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = 3'b000;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Capture buffers: a granted source may be refilled by a rise in the same cycle without loss.
  always_comb begin
    rise_s     = flag_s & ~flag_q;
    pend_d     = pend_q;
    abuf_d     = abuf_q;
    dbuf_d     = dbuf_q;
    drop_inc_s = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (!i_src_en[i]) begin
        pend_d[i] = 1'b0;
      end else if (rise_s[i]) begin
        if ({1'b0, addr_in_s[i]} > MAX_A) begin
          drop_inc_s = drop_inc_s + 2'd1;
          pend_d[i]  = pend_q[i] & ~take_s[i];
        end else begin
          pend_d[i]  = 1'b1;
          abuf_d[i]  = addr_in_s[i];
          dbuf_d[i]  = data_in_s[i];
          drop_inc_s = drop_inc_s + {1'b0, pend_q[i] & ~take_s[i]};
        end
      end else begin
        pend_d[i] = pend_q[i] & ~take_s[i];
      end
    end
    drop_sum_s = {2'b00, drop_q} + {{CNT_W{1'b0}}, drop_inc_s};
    if (drop_sum_s > {2'b00, {CNT_W{1'b1}}}) begin
      drop_d = {CNT_W{1'b1}};
    end else begin
      drop_d = drop_sum_s[CNT_W-1:0];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      flag_q  <= 3'b000;
      pend_q  <= 3'b000;
      abuf_q  <= '{default: '0};
      dbuf_q  <= '{default: '0};
      rr_q    <= 1'b0;
      adr_q   <= {ADDR_W{1'b0}};
      d_q     <= {DATA_W{1'b0}};
      grant_q <= 3'b000;
      wen_q   <= 1'b1;
      busy_q  <= 1'b0;
      drop_q  <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      flag_q  <= flag_s;
      pend_q  <= pend_d;
      abuf_q  <= abuf_d;
      dbuf_q  <= dbuf_d;
      rr_q    <= rr_d;
      adr_q   <= adr_d;
      d_q     <= d_d;
      grant_q <= grant_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  assign disp.wen   = wen_q;
  assign disp.men   = wen_q;
  assign disp.adr   = adr_q;
  assign disp.d     = d_q;
  assign o_grant    = grant_q;
  assign o_busy     = busy_q;
  assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_disp_wr_arbiter.sv
// Directed bench for disp_wr_arbiter: priority, round-robin, overwrite, drop counting, flush, reset.
module tb_disp_wr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] src_en;
  logic       err_flag, rx_flag, tx_flag;
  logic [6:0] err_addr, rx_addr, tx_addr;
  logic [3:0] err_data, rx_data, tx_data;
  logic [2:0] grant;
  logic       busy;
  logic [7:0] drop;

  int         n_total = 0;
  int         n_bad   = 0;
  int         wr_n    = 0;
  logic [2:0] wr_g [8];
  logic [6:0] wr_a [8];
  logic [3:0] wr_d [8];

  always #5 clk = ~clk;

  disp_wr_if dif ();

  disp_wr_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_src_en   (src_en),
    .i_err_flag (err_flag),
    .i_err_addr (err_addr),
    .i_err_data (err_data),
    .i_rx_flag  (rx_flag),
    .i_rx_addr  (rx_addr),
    .i_rx_data  (rx_data),
    .i_tx_flag  (tx_flag),
    .i_tx_addr  (tx_addr),
    .i_tx_data  (tx_data),
    .disp       (dif),
    .o_grant    (grant),
    .o_busy     (busy),
    .o_drop_cnt (drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1ns after the edge and log every write strobe.
  task automatic tick();
    @(posedge clk);
    #1;
    if (dif.wen === 1'b0) begin
      chk("men_eq_wen", {31'd0, dif.men}, 32'd0);
      if (wr_n < 8) begin
        wr_g[wr_n] = grant;
        wr_a[wr_n] = dif.adr;
        wr_d[wr_n] = dif.d;
      end
      wr_n++;
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    src_en   = 3'b111;
    err_flag = 1'b0; rx_flag = 1'b0; tx_flag = 1'b0;
    err_addr = 7'd0; rx_addr = 7'd0; tx_addr = 7'd0;
    err_data = 4'd0; rx_data = 4'd0; tx_data = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr_n  = 0;
  endtask

  initial begin
    // Reset values
    rst_n    = 1'b0;
    src_en   = 3'b111;
    err_flag = 1'b0; rx_flag = 1'b0; tx_flag = 1'b0;
    err_addr = 7'd0; rx_addr = 7'd0; tx_addr = 7'd0;
    err_data = 4'd0; rx_data = 4'd0; tx_data = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen",   {31'd0, dif.wen}, 32'd1);
    chk("rst_men",   {31'd0, dif.men}, 32'd1);
    chk("rst_adr",   {25'd0, dif.adr}, 32'd0);
    chk("rst_d",     {28'd0, dif.d},   32'd0);
    chk("rst_grant", {29'd0, grant},   32'd0);
    chk("rst_busy",  {31'd0, busy},    32'd0);
    chk("rst_drop",  {24'd0, drop},    32'd0);
    rst_n = 1'b1;
    wr_n  = 0;

    // Single RX write: addr 5, digit 7, strobe low two cycles after the capturing edge
    rx_addr = 7'd5; rx_data = 4'd7; rx_flag = 1'b1;
    tick();
    rx_flag = 1'b0;
    chk("a_n_busy", {31'd0, busy}, 32'd0);
    chk("a_n_wen",  {31'd0, dif.wen}, 32'd1);
    tick();
    chk("a_n1_busy",  {31'd0, busy},    32'd1);
    chk("a_n1_grant", {29'd0, grant},   32'd2);
    chk("a_n1_adr",   {25'd0, dif.adr}, 32'd5);
    chk("a_n1_d",     {28'd0, dif.d},   32'd7);
    chk("a_n1_wen",   {31'd0, dif.wen}, 32'd1);
    tick();
    chk("a_n2_wen", {31'd0, dif.wen}, 32'd0);
    chk("a_n2_adr", {25'd0, dif.adr}, 32'd5);
    tick();
    chk("a_n3_wen",   {31'd0, dif.wen}, 32'd1);
    chk("a_n3_grant", {29'd0, grant},   32'd2);
    tick();
    chk("a_n4_grant", {29'd0, grant}, 32'd0);
    chk("a_n4_busy",  {31'd0, busy},  32'd0);
    repeat (4) tick();
    chk("a_wr_n", wr_n, 32'd1);

    // ERR, RX, TX rise together: written in ERR, RX, TX order
    do_reset();
    err_addr = 7'd10; err_data = 4'd1;
    rx_addr  = 7'd20; rx_data  = 4'd2;
    tx_addr  = 7'd30; tx_data  = 4'd3;
    err_flag = 1'b1; rx_flag = 1'b1; tx_flag = 1'b1;
    tick();
    err_flag = 1'b0; rx_flag = 1'b0; tx_flag = 1'b0;
    repeat (16) tick();
    chk("b_wr_n", wr_n, 32'd3);
    chk("b_g0", {29'd0, wr_g[0]}, 32'd4);
    chk("b_a0", {25'd0, wr_a[0]}, 32'd10);
    chk("b_d0", {28'd0, wr_d[0]}, 32'd1);
    chk("b_g1", {29'd0, wr_g[1]}, 32'd2);
    chk("b_a1", {25'd0, wr_a[1]}, 32'd20);
    chk("b_d1", {28'd0, wr_d[1]}, 32'd2);
    chk("b_g2", {29'd0, wr_g[2]}, 32'd1);
    chk("b_a2", {25'd0, wr_a[2]}, 32'd30);
    chk("b_d2", {28'd0, wr_d[2]}, 32'd3);
    chk("b_drop", {24'd0, drop}, 32'd0);

    // RX rises twice while pending behind a TX write: only the second digit is written
    do_reset();
    tx_addr = 7'd40; tx_data = 4'd4; tx_flag = 1'b1;
    tick();
    tx_flag = 1'b0;
    rx_addr = 7'd9; rx_data = 4'd1; rx_flag = 1'b1;
    tick();
    rx_flag = 1'b0;
    tick();
    rx_data = 4'd2; rx_flag = 1'b1;
    tick();
    rx_flag = 1'b0;
    repeat (12) tick();
    chk("c_wr_n", wr_n, 32'd2);
    chk("c_g0",   {29'd0, wr_g[0]}, 32'd1);
    chk("c_a0",   {25'd0, wr_a[0]}, 32'd40);
    chk("c_g1",   {29'd0, wr_g[1]}, 32'd2);
    chk("c_a1",   {25'd0, wr_a[1]}, 32'd9);
    chk("c_d1",   {28'd0, wr_d[1]}, 32'd2);
    chk("c_drop", {24'd0, drop},    32'd1);

    // Address boundary and simultaneous drops: 122 accepted, 123 and 127 dropped
    do_reset();
    err_addr = 7'd122; err_data = 4'd5;
    rx_addr  = 7'd123; tx_addr  = 7'd127;
    err_flag = 1'b1; rx_flag = 1'b1; tx_flag = 1'b1;
    tick();
    err_flag = 1'b0; rx_flag = 1'b0; tx_flag = 1'b0;
    repeat (8) tick();
    chk("d_wr_n", wr_n, 32'd1);
    chk("d_g0",   {29'd0, wr_g[0]}, 32'd4);
    chk("d_a0",   {25'd0, wr_a[0]}, 32'd122);
    chk("d_d0",   {28'd0, wr_d[0]}, 32'd5);
    chk("d_drop2", {24'd0, drop},   32'd2);

    // Saturation: 300 further bad TX requests
    tx_addr = 7'd123;
    for (int k = 0; k < 252; k++) begin
      tx_flag = 1'b1; tick();
      tx_flag = 1'b0; tick();
    end
    chk("d_drop254", {24'd0, drop}, 32'd254);
    for (int k = 0; k < 48; k++) begin
      tx_flag = 1'b1; tick();
      tx_flag = 1'b0; tick();
    end
    chk("d_drop_sat", {24'd0, drop}, 32'd255);
    chk("d_no_more_wr", wr_n, 32'd1);

    // Pending ERR flushed by disabling it; never written, not counted
    do_reset();
    rx_addr = 7'd50; rx_data = 4'd6; rx_flag = 1'b1;
    tick();
    rx_flag = 1'b0;
    err_addr = 7'd60; err_data = 4'd8; err_flag = 1'b1;
    tick();
    err_flag = 1'b0;
    src_en   = 3'b011;
    tick();
    src_en   = 3'b111;
    repeat (12) tick();
    chk("e_wr_n", wr_n, 32'd1);
    chk("e_g0",   {29'd0, wr_g[0]}, 32'd2);
    chk("e_a0",   {25'd0, wr_a[0]}, 32'd50);
    chk("e_drop", {24'd0, drop},    32'd0);

    // Single bad TX request, then asynchronous reset in the middle of a write strobe
    do_reset();
    tx_addr = 7'd123; tx_flag = 1'b1;
    tick();
    tx_flag = 1'b0;
    repeat (6) tick();
    chk("f_drop1", {24'd0, drop}, 32'd1);
    chk("f_no_wr", wr_n, 32'd0);
    rx_addr = 7'd70; rx_data = 4'd9; rx_flag = 1'b1;
    tick();
    rx_flag = 1'b0;
    tick();
    tick();
    chk("f_mid_wen", {31'd0, dif.wen}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("f_arst_wen",   {31'd0, dif.wen}, 32'd1);
    chk("f_arst_men",   {31'd0, dif.men}, 32'd1);
    chk("f_arst_grant", {29'd0, grant},   32'd0);
    chk("f_arst_busy",  {31'd0, busy},    32'd0);
    chk("f_arst_drop",  {24'd0, drop},    32'd0);
    chk("f_arst_adr",   {25'd0, dif.adr}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
